// File: rtl/tm1638_frame_ctrl_if.sv
// Host-side byte fetch, frame handshake and TM1638 transmitter drive signals
// of the TM1638 frame sequencer, bundled with direction-specific views.
interface tm1638_frame_ctrl_if;
  logic       start;
  logic [4:0] frame_len;
  logic [4:0] byte_idx;
  logic [7:0] byte_data;
  logic       busy;
  logic       done;
  logic       stb;
  logic       sclk;
  logic       tx_start;
  logic [7:0] wdata;
  logic       clk_fall;

  // Host / bench side: requests frames, serves bytes, observes the TM1638 lines.
  modport master (
    output start, frame_len, byte_data,
    input  byte_idx, busy, done, stb, sclk, tx_start, wdata, clk_fall
  );

  // Sequencer side.
  modport slave (
    input  start, frame_len, byte_data,
    output byte_idx, busy, done, stb, sclk, tx_start, wdata, clk_fall
  );
endinterface

// File: rtl/tm1638_frame_ctrl.sv
// TM1638 frame sequencer: generates STB/CLK from mclk, fetches frame bytes
// from the host buffer and paces the downstream bit transmitter so that one
// STB-low command frame is shifted out LSB-first per start request.
module tm1638_frame_ctrl #(
  parameter int CLK_DIV = 8,
  parameter int MAX_LEN = 17
) (
  input logic                mclk,
  input logic                rst,
  tm1638_frame_ctrl_if.slave bus
);

  localparam logic [7:0] DIV_LAST = 8'(CLK_DIV - 1);
  localparam logic [4:0] LEN_CAP  = 5'(MAX_LEN);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SETUP = 3'd1,
    LOW   = 3'd2,
    HIGH  = 3'd3,
    HOLD  = 3'd4,
    GAP   = 3'd5
  } state_t;

  state_t     state, state_nxt;
  logic [7:0] div_cnt, div_nxt;
  logic [2:0] bit_cnt, bit_nxt;
  logic [4:0] byte_cnt, byte_nxt;
  logic [4:0] len, len_nxt;
  logic       load_pend, load_nxt;
  logic       stb, stb_nxt;
  logic       sclk, sclk_nxt;
  logic       tx_start, tx_nxt;
  logic [7:0] wdata, wdata_nxt;
  logic       clk_fall, cf_nxt;
  logic       busy, busy_nxt;
  logic       done, done_nxt;

  logic div_end;
  logic last_byte;

  // Saturate the requested byte count to the largest frame the TM1638 takes.
  function automatic logic [4:0] clamp_len(input logic [4:0] req);
    return (req > LEN_CAP) ? LEN_CAP : req;
  endfunction

  assign div_end   = (div_cnt == DIV_LAST);
  assign last_byte = (byte_cnt == len - 5'd1);

  // Next-state and next-output decode; every phase lasts exactly CLK_DIV cycles.
  always_comb begin
    state_nxt = state;
    div_nxt   = div_end ? 8'd0 : div_cnt + 8'd1;
    bit_nxt   = bit_cnt;
    byte_nxt  = byte_cnt;
    len_nxt   = len;
    load_nxt  = 1'b0;
    stb_nxt   = stb;
    sclk_nxt  = sclk;
    tx_nxt    = 1'b0;
    wdata_nxt = wdata;
    cf_nxt    = 1'b0;
    busy_nxt  = busy;
    done_nxt  = 1'b0;

    case (state)
      IDLE: begin
        div_nxt = 8'd0;
        if (bus.start) begin
          if (bus.frame_len != 5'd0) begin
            len_nxt   = clamp_len(bus.frame_len);
            stb_nxt   = 1'b0;
            busy_nxt  = 1'b1;
            byte_nxt  = 5'd0;
            bit_nxt   = 3'd0;
            state_nxt = SETUP;
          end else begin
            done_nxt = 1'b1;
          end
        end
      end
      SETUP: begin
        if (div_end) begin
          wdata_nxt = bus.byte_data;
          tx_nxt    = 1'b1;
          sclk_nxt  = 1'b0;
          state_nxt = LOW;
        end
      end
      LOW: begin
        // Next byte is loaded one cycle into LOW so the transmitter's final
        // clk_fall of the previous byte still sees the old wdata.
        if (load_pend) begin
          wdata_nxt = bus.byte_data;
          tx_nxt    = 1'b1;
        end
        if (div_end) begin
          sclk_nxt  = 1'b1;
          state_nxt = HIGH;
        end
      end
      HIGH: begin
        if (div_end) begin
          cf_nxt  = 1'b1;
          bit_nxt = bit_cnt + 3'd1;
          if (bit_cnt != 3'd7) begin
            sclk_nxt  = 1'b0;
            state_nxt = LOW;
          end else if (!last_byte) begin
            sclk_nxt  = 1'b0;
            byte_nxt  = byte_cnt + 5'd1;
            load_nxt  = 1'b1;
            state_nxt = LOW;
          end else begin
            state_nxt = HOLD;
          end
        end
      end
      HOLD: begin
        if (div_end) begin
          stb_nxt   = 1'b1;
          state_nxt = GAP;
        end
      end
      GAP: begin
        if (div_end) begin
          done_nxt  = 1'b1;
          busy_nxt  = 1'b0;
          state_nxt = IDLE;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // State, counters and registered outputs; reset forces STB/CLK high at once.
  always_ff @(posedge mclk) begin
    if (rst) begin
      state     <= IDLE;
      div_cnt   <= 8'd0;
      bit_cnt   <= 3'd0;
      byte_cnt  <= 5'd0;
      len       <= 5'd0;
      load_pend <= 1'b0;
      stb       <= 1'b1;
      sclk      <= 1'b1;
      tx_start  <= 1'b0;
      wdata     <= 8'h00;
      clk_fall  <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      state     <= state_nxt;
      div_cnt   <= div_nxt;
      bit_cnt   <= bit_nxt;
      byte_cnt  <= byte_nxt;
      len       <= len_nxt;
      load_pend <= load_nxt;
      stb       <= stb_nxt;
      sclk      <= sclk_nxt;
      tx_start  <= tx_nxt;
      wdata     <= wdata_nxt;
      clk_fall  <= cf_nxt;
      busy      <= busy_nxt;
      done      <= done_nxt;
    end
  end

  assign bus.byte_idx = byte_cnt;
  assign bus.busy     = busy;
  assign bus.done     = done;
  assign bus.stb      = stb;
  assign bus.sclk     = sclk;
  assign bus.tx_start = tx_start;
  assign bus.wdata    = wdata;
  assign bus.clk_fall = clk_fall;

endmodule
